fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/common_pkg.sv | 8 +
 rtl/pipes_pkg.sv | 14 +
 rtl/fetch_queue_ram.sv | 24 ++
 rtl/fetch_queue.sv | 83 ++++++++
 tb/tb_fetch_queue.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Common scalar types shared across the pipeline.
package common_pkg;

  typedef logic        u1;
  typedef logic [31:0] u32;
  typedef logic [63:0] addr_t;

endpackage

// File: rtl/pipes_pkg.sv
// Inter-stage payload types and default sizing for the fetch/decode boundary.
package pipes_pkg;

  import common_pkg::*;

  localparam int FETCH_QUEUE_DEPTH = 4;

  typedef struct packed {
    u1     valid;
    u32    raw_instr;
    addr_t pc;
  } fetch_data_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Storage for the fetch queue: DEPTH x fetch_data_t, one write port, one async read port.
module fetch_queue_ram
  import pipes_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  fetch_data_t                wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output fetch_data_t                rdata
);

  fetch_data_t mem [DEPTH];

  // NOTE: storage has no reset; the pointers guarantee stale words are never presented as valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with wrap-bit pointers and flush.
// Define FETCH_QUEUE_BYPASS_EN to forward dataF straight to dataD when the queue is empty.
module fetch_queue
  import common_pkg::*;
  import pipes_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  fetch_data_t              dataF,
  output logic                     in_ready,
  output fetch_data_t              dataD,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic                     sctlQ,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  u1           empty;
  u1           full;
  u1           push;
  u1           pop;
  u1           write;
  u1           bypass_hit;
  fetch_data_t head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  assign in_ready = !full;
  assign sctlQ    = full;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = empty && dataF.valid && !flush;
`else
  assign bypass_hit = 1'b0;
`endif

  assign push  = dataF.valid && in_ready && !flush;
  assign pop   = !empty && out_ready && !flush;
  // A bypassed entry consumed in the same cycle never occupies a slot.
  assign write = push && !(bypass_hit && out_ready);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dataD = head;
    if (empty) dataD = bypass_hit ? dataF : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (write) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)   rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (write),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (dataF),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  import pipes_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  fetch_data_t dataF;
  logic        in_ready;
  fetch_data_t dataD;
  logic        out_ready;
  logic        flush;
  logic        sctlQ;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_data_t model_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .dataF     (dataF),
    .in_ready  (in_ready),
    .dataD     (dataD),
    .out_ready (out_ready),
    .flush     (flush),
    .sctlQ     (sctlQ),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fetch_data_t exp_dataD();
    fetch_data_t r = '0;
    if (model_q.size() != 0) r = model_q[0];
    else if (BYPASS && dataF.valid && !flush) r = dataF;
    return r;
  endfunction

  // Apply the queue rules to the model for the upcoming edge.
  task automatic model_edge();
    int n = model_q.size();
    if (flush) begin
      model_q.delete();
    end else begin
      if (n > 0 && out_ready) model_q.delete(0);
      if (dataF.valid && n < DEPTH && !(BYPASS && n == 0 && out_ready))
        model_q.push_back(dataF);
    end
  endtask

  task automatic drive(input bit v, input logic [63:0] pc, input logic ordy, input logic fl);
    dataF.valid     = v;
    dataF.pc        = pc;
    dataF.raw_instr = $urandom;
    out_ready       = ordy;
    flush           = fl;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dataF = '0; out_ready = 1'b0; flush = 1'b0;
    #2;
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (dataD !== '0) begin n_bad++; $display("FAIL reset_dataD: got %h want 0", dataD); end
    n_cmp++; if (in_ready !== 1'b1 || sctlQ !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready: got in_ready=%b sctlQ=%b want 1/0", in_ready, sctlQ); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0);
      tick();
      n_cmp++; if (count !== 3'(i + 1)) begin
        n_bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
    end
    drive(1'b1, 64'h8000_0010, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b0 || sctlQ !== 1'b1) begin
      n_bad++; $display("FAIL fill_full: got in_ready=%b sctlQ=%b want 0/1", in_ready, sctlQ); end
    tick();
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fill_drop: got %0d want 4", count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      n_cmp++; if (dataD.valid !== 1'b1 || dataD.pc !== 64'h8000_0000 + 64'(4 * i)) begin
        n_bad++; $display("FAIL drain_pc[%0d]: got v=%b pc=%h want v=1 pc=%h",
                          i, dataD.valid, dataD.pc, 64'h8000_0000 + 64'(4 * i)); end
      tick();
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (dataD !== '0 || count !== 3'd0) begin
      n_bad++; $display("FAIL drain_empty: got dataD=%h count=%0d want 0/0", dataD, count); end
  endtask

  task automatic test_wrap();
    logic [63:0] emitted[$];
    logic [2:0]  steady;
    steady = '0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b1, 1'b0);
      n_cmp++; if (dataD !== exp_dataD()) begin
        n_bad++; $display("FAIL wrap_dataD[%0d]: got %h want %h", i, dataD, exp_dataD()); end
      if (dataD.valid) emitted.push_back(dataD.pc);
      tick();
      if (i == 0) steady = count;
      n_cmp++; if (count !== steady || count !== 3'(model_q.size())) begin
        n_bad++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, count, model_q.size()); end
    end
    for (int k = 0; k < 2 * DEPTH; k++) begin
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      if (!dataD.valid) break;
      emitted.push_back(dataD.pc);
      tick();
    end
    n_cmp++; if (emitted.size() != 20) begin
      n_bad++; $display("FAIL wrap_total: got %0d want 20", emitted.size()); end
    for (int i = 0; i < emitted.size() && i < 20; i++) begin
      n_cmp++; if (emitted[i] !== 64'h8000_0000 + 64'(4 * i)) begin
        n_bad++; $display("FAIL wrap_order[%0d]: got %h want %h", i, emitted[i], 64'h8000_0000 + 64'(4 * i)); end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h8000_0200 + 64'(4 * i), 1'b0, 1'b0);
      tick();
    end
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL flush_pre: got %0d want 3", count); end
    drive(1'b1, 64'h8000_0100, 1'b1, 1'b1);
    tick();
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    n_cmp++; if (count !== 3'd0 || dataD.valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_post: got count=%0d valid=%b want 0/0", count, dataD.valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (dataD.valid !== 1'b0) begin
        n_bad++; $display("FAIL flush_leak[%0d]: got pc=%h want no entry", i, dataD.pc); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h8000_0300 + 64'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (count !== 3'd2) begin n_bad++; $display("FAIL areset_pre: got %0d want 2", count); end
    #1;
    reset = 1'b1;
    model_q.delete();
    #1;
    n_cmp++; if (dataD.valid !== 1'b0 || in_ready !== 1'b1 || sctlQ !== 1'b0 || count !== 3'd0) begin
      n_bad++; $display("FAIL areset_now: got valid=%b in_ready=%b sctlQ=%b count=%0d want 0/1/0/0",
                        dataD.valid, in_ready, sctlQ, count); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 64'h8000_0000, 1'b1, 1'b0);
    n_cmp++; if (dataD.valid !== BYPASS || (BYPASS && dataD.pc !== 64'h8000_0000)) begin
      n_bad++; $display("FAIL bypass_same: got v=%b pc=%h want v=%b", dataD.valid, dataD.pc, BYPASS); end
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    n_cmp++; if (count !== 3'(!BYPASS) || dataD.valid !== !BYPASS) begin
      n_bad++; $display("FAIL bypass_next: got count=%0d v=%b want %0d/%b", count, dataD.valid, !BYPASS, !BYPASS); end
    if (!BYPASS) begin
      n_cmp++; if (dataD.pc !== 64'h8000_0000) begin
        n_bad++; $display("FAIL bypass_latency_pc: got %h want 80000000", dataD.pc); end
    end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, {32'h8000_0000, 32'($urandom)},
            1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      n_cmp++; if (dataD !== exp_dataD()) begin
        n_bad++; $display("FAIL rand_dataD[%0d]: got %h want %h", i, dataD, exp_dataD()); end
      n_cmp++; if (count !== 3'(model_q.size()) || in_ready !== (model_q.size() < DEPTH)
                   || sctlQ !== (model_q.size() >= DEPTH)) begin
        n_bad++; $display("FAIL rand_status[%0d]: got count=%0d in_ready=%b sctlQ=%b want count=%0d",
                          i, count, in_ready, sctlQ, model_q.size()); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_flush();
    test_async_reset();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
